// File: rtl/reaction_display_driver.sv
// ---------------------------------------------------------------------------
// reaction_display_driver
//
// Converts a 16-bit binary reaction count to five BCD digits with a
// sequential double-dabble engine. The display is an 8-digit multiplexed
// seven-segment panel. Converted digits are committed atomically, so the
// panel never shows a half-finished conversion. The scan runs continuously
// and shows one of four content modes.
//
// Conversion FSM
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for load; loads arriving here start a conversion
//   SHIFT  | 16 double-dabble iterations, one per cycle; load ignored
//   COMMIT | copy scratch BCD into displayed digits, then pulse done
//
// Ports
//   CLK100MHZ  in   system clock, rising edge
//   BTNU       in   asynchronous active-high reset
//   value[15:0] in  unsigned binary count to convert
//   load       in   single-cycle conversion request (honoured only in IDLE)
//   mode[1:0]  in   00 blank, 01 number, 10 "ALOHA", 11 dashes
//   busy       out  high during SHIFT and COMMIT
//   done       out  one-cycle pulse in the cycle new digits first appear
//   AN[7:0]    out  active-low anodes, AN[7] leftmost
//   seg[7:0]   out  active-low {DP,CG,CF,CE,CD,CC,CB,CA}
// ---------------------------------------------------------------------------
module reaction_display_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        CLK100MHZ,
   input  logic        BTNU,
   input  logic [15:0] value,
   input  logic        load,
   input  logic [1:0]  mode,
   output logic        busy,
   output logic        done,
   output logic [7:0]  AN,
   output logic [7:0]  seg
);

   localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   localparam logic [7:0] SEG_OFF  = 8'hFF;
   localparam logic [7:0] SEG_DASH = 8'hBF;
   localparam logic [7:0] SEG_A    = 8'h88;
   localparam logic [7:0] SEG_L    = 8'hC7;
   localparam logic [7:0] SEG_O    = 8'hC0;
   localparam logic [7:0] SEG_H    = 8'h89;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Conversion engine
   // ------------------------------------------------------------------
   state_t      state_q;
   logic [15:0] bin_q;
   logic [19:0] bcd_q;
   logic [4:0]  iter_q;
   logic [19:0] digits_q;
   logic        busy_q;
   logic        done_q;

   logic [19:0] bcd_adj;

   // Add-3 correction on every nibble that would overflow past 9 once doubled.
   always_comb begin
      bcd_adj = bcd_q;
      for (int n = 0; n < 5; n++) begin
         if (bcd_q[4*n +: 4] >= 4'd5) begin
            bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or posedge BTNU) begin
      if (BTNU) begin
         state_q  <= IDLE;
         bin_q    <= '0;
         bcd_q    <= '0;
         iter_q   <= '0;
         digits_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (load) begin
                  bin_q   <= value;
                  bcd_q   <= '0;
                  iter_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               {bcd_q, bin_q} <= {bcd_adj[18:0], bin_q, 1'b0};
               iter_q         <= iter_q + 5'd1;
               if (iter_q == 5'd15) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               // done rises together with the new digits, so a reset landing
               // in COMMIT suppresses both.
               digits_q <= bcd_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   // ------------------------------------------------------------------
   // Refresh divider and digit index
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div_q, div_d;
   logic [2:0]       idx_q, idx_d;

   always_comb begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = idx_q + 3'd1;
      end
   end

   always_ff @(posedge CLK100MHZ or posedge BTNU) begin
      if (BTNU) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
      end
   end

   // ------------------------------------------------------------------
   // Digit content for the current slot
   // ------------------------------------------------------------------
   function automatic logic [7:0] seg_of_bcd(input logic [3:0] d);
      logic [7:0] s;
      unique case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

   logic [3:0] d0, d1, d2, d3, d4;
   logic [4:0] num_lit;

   assign d0 = digits_q[3:0];
   assign d1 = digits_q[7:4];
   assign d2 = digits_q[11:8];
   assign d3 = digits_q[15:12];
   assign d4 = digits_q[19:16];

   // Leading-zero blanking: a digit is lit once it or any higher digit is
   // non-zero; the units digit is always lit so zero reads "0".
   always_comb begin
      num_lit[4] = (d4 != 4'd0);
      num_lit[3] = num_lit[4] | (d3 != 4'd0);
      num_lit[2] = num_lit[3] | (d2 != 4'd0);
      num_lit[1] = num_lit[2] | (d1 != 4'd0);
      num_lit[0] = 1'b1;
   end

   logic [3:0] slot_nib;
   logic       slot_num_lit;
   logic [7:0] slot_txt;
   logic       slot_in_num;
   logic       slot_in_dash;

   always_comb begin
      slot_nib     = 4'd0;
      slot_num_lit = 1'b0;
      slot_txt     = SEG_OFF;
      slot_in_num  = 1'b0;
      slot_in_dash = 1'b0;
      unique case (idx_q)
         3'd0: begin
            slot_nib = d0; slot_num_lit = num_lit[0]; slot_txt = SEG_A;
            slot_in_num = 1'b1; slot_in_dash = 1'b1;
         end
         3'd1: begin
            slot_nib = d1; slot_num_lit = num_lit[1]; slot_txt = SEG_H;
            slot_in_num = 1'b1; slot_in_dash = 1'b1;
         end
         3'd2: begin
            slot_nib = d2; slot_num_lit = num_lit[2]; slot_txt = SEG_O;
            slot_in_num = 1'b1; slot_in_dash = 1'b1;
         end
         3'd3: begin
            slot_nib = d3; slot_num_lit = num_lit[3]; slot_txt = SEG_L;
            slot_in_num = 1'b1; slot_in_dash = 1'b1;
         end
         3'd4: begin
            slot_nib = d4; slot_num_lit = num_lit[4]; slot_txt = SEG_A;
            slot_in_num = 1'b1;
         end
         default: begin
            slot_nib     = 4'd0;
            slot_num_lit = 1'b0;
            slot_txt     = SEG_OFF;
         end
      endcase
   end

   logic [7:0] an_d, seg_d, an_q, seg_q;
   logic       lit;

   always_comb begin
      lit   = 1'b0;
      seg_d = SEG_OFF;
      unique case (mode)
         2'b01: begin
            lit   = slot_in_num & slot_num_lit;
            seg_d = lit ? seg_of_bcd(slot_nib) : SEG_OFF;
         end
         2'b10: begin
            lit   = slot_in_num;
            seg_d = lit ? slot_txt : SEG_OFF;
         end
         2'b11: begin
            lit   = slot_in_dash;
            seg_d = lit ? SEG_DASH : SEG_OFF;
         end
         default: begin
            lit   = 1'b0;
            seg_d = SEG_OFF;
         end
      endcase
      an_d = lit ? ~(8'h01 << idx_q) : 8'hFF;
   end

   always_ff @(posedge CLK100MHZ or posedge BTNU) begin
      if (BTNU) begin
         an_q  <= 8'hFF;
         seg_q <= SEG_OFF;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign AN  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_reaction_display_driver.sv
// ---------------------------------------------------------------------------
// tb_reaction_display_driver
//
// Random and directed loads/modes against a cycle-level reference model.
// The driver decides from its own bookkeeping whether a load is accepted and
// pushes the expected done cycle and commit cycle into queues; a negedge
// monitor pops and compares on done, and checks AN/seg/busy every cycle
// against a model of the display computed with decimal arithmetic.
// ---------------------------------------------------------------------------
module tb_reaction_display_driver;

   localparam int DIV = 4;

   logic        clk;
   logic        btnu;
   logic [15:0] value;
   logic        load;
   logic [1:0]  mode;
   logic        busy;
   logic        done;
   logic [7:0]  an;
   logic [7:0]  sg;

   reaction_display_driver #(.REFRESH_DIV(DIV)) dut (
      .CLK100MHZ (clk),
      .BTNU      (btnu),
      .value     (value),
      .load      (load),
      .mode      (mode),
      .busy      (busy),
      .done      (done),
      .AN        (an),
      .seg       (sg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int val;
      int cyc;
   } ev_t;

   ev_t done_sb[$];
   ev_t commit_sb[$];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int last_l  = -1000;
   int shown   = 0;
   logic [1:0] mode_at_edge = 2'b00;

   logic [7:0] num_code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   // "ALOHA" read right to left: slot 0 is the rightmost A.
   logic [7:0] txt_code [5]  = '{8'h88, 8'h89, 8'hC0, 8'hC7, 8'h88};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
   endtask

   task automatic flag(input string name, input int a, input int e);
      n_total++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, a, e, cyc, $time);
   endtask

   function automatic void exp_disp(input int v, input logic [1:0] m, input int s,
                                    output logic [7:0] e_an, output logic [7:0] e_sg);
      int p;
      bit lit;
      lit  = 0;
      e_sg = 8'hFF;
      p    = 1;
      for (int j = 0; j < s; j++) p = p * 10;
      case (m)
         2'd1: if (s <= 4 && (s == 0 || v >= p)) begin
            lit  = 1;
            e_sg = num_code[(v / p) % 10];
         end
         2'd2: if (s <= 4) begin
            lit  = 1;
            e_sg = txt_code[s];
         end
         2'd3: if (s <= 3) begin
            lit  = 1;
            e_sg = 8'hBF;
         end
         default: lit = 0;
      endcase
      e_an = lit ? ~(8'h01 << s) : 8'hFF;
   endfunction

   // Edge counter since reset release, and the mode the DUT saw at each edge.
   always @(posedge clk) begin
      mode_at_edge = mode;
      if (btnu) cyc = 0;
      else      cyc = cyc + 1;
   end

   // Monitor
   always @(negedge clk) begin
      logic [7:0] e_an, e_sg;
      int k;
      if (btnu) begin
         shown = 0;
         chk("rst_an", an, 8'hFF);
         chk("rst_seg", sg, 8'hFF);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
      end else begin
         k = cyc;
         while (commit_sb.size() > 0 && commit_sb[0].cyc <= k - 1) begin
            shown = commit_sb[0].val;
            void'(commit_sb.pop_front());
         end
         if (k == 0) begin
            e_an = 8'hFF;
            e_sg = 8'hFF;
         end else begin
            exp_disp(shown, mode_at_edge, ((k - 1) / DIV) % 8, e_an, e_sg);
         end
         chk("an", an, e_an);
         chk("seg", sg, e_sg);
         chk("busy", busy, (k >= last_l && k <= last_l + 16) ? 1 : 0);
         if (done === 1'b1) begin
            if (done_sb.size() == 0) flag("unexpected_done", k, -1);
            else begin
               chk("done_cycle", k, done_sb[0].cyc);
               void'(done_sb.pop_front());
            end
         end else if (done_sb.size() > 0 && k > done_sb[0].cyc) begin
            flag("done_timeout", k, done_sb[0].cyc);
            void'(done_sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic issue_load(input int v);
      int l;
      ev_t e;
      value = 16'(v);
      load  = 1'b1;
      l     = cyc + 1;
      if (l >= last_l + 18) begin
         e.val = v;
         e.cyc = l + 17;
         done_sb.push_back(e);
         commit_sb.push_back(e);
         last_l = l;
      end
      step();
      load = 1'b0;
   endtask

   task automatic do_reset(input int n);
      btnu   = 1'b1;
      load   = 1'b0;
      done_sb.delete();
      commit_sb.delete();
      last_l = -1000;
      run(n);
      btnu   = 1'b0;
   endtask

   int bnd [7] = '{0, 9, 10, 99, 100, 9999, 65535};

   initial begin
      int v;
      btnu  = 1'b0;
      load  = 1'b0;
      value = '0;
      mode  = 2'b01;
      #1;
      btnu = 1'b1;
      step();
      do_reset(3);

      // Number display, ascending digits, then boundaries
      issue_load(1234);
      run(60);
      issue_load(0);
      run(50);
      issue_load(65535);
      run(50);

      // Load during SHIFT is dropped
      issue_load(500);
      run(4);
      issue_load(9);
      run(60);

      // Text, dashes, blank
      mode = 2'b10; run(40);
      mode = 2'b11; run(40);
      mode = 2'b00; run(40);

      // Abort mid-SHIFT
      mode = 2'b01;
      issue_load(4321);
      run(7);
      do_reset(3);
      run(40);

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) v = bnd[$urandom_range(0, 6)];
         else                           v = int'($urandom_range(0, 65535));
         if ($urandom_range(0, 3) != 0) mode = 2'b01;
         else                           mode = 2'($urandom_range(0, 3));
         issue_load(v);
         run($urandom_range(0, 60));
      end

      mode = 2'b01;
      for (int i = 0; i < 300 && done_sb.size() > 0; i++) step();
      if (done_sb.size() > 0) flag("drain_timeout", done_sb.size(), 0);
      run(40);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
